// File: rtl/stream_upsizer_pkg.sv
// Shared types and helpers for the stream upsizer.
package stream_pkg;

   // The upsizer has two states: gathering beats, or presenting a finished word.
   typedef enum logic {
      FILL,
      HOLD
   } upsz_state_t;

   // Returns the bit width of the lane index for a word of `ratio` lanes.
   function automatic int unsigned lane_w(input int unsigned ratio);
      return (ratio < 2) ? 1 : $clog2(ratio);
   endfunction

endpackage

// File: rtl/stream_upsizer_if.sv
// Narrow-in / wide-out stream bundle for the upsizer.
interface stream_upsizer_if #(
   parameter int unsigned IN_W  = 8,
   parameter int unsigned RATIO = 4
);

   logic                    in_valid;
   logic                    in_ready;
   logic [IN_W-1:0]         in_data;
   logic                    in_last;
   logic                    out_valid;
   logic                    out_ready;
   logic [IN_W*RATIO-1:0]   out_data;
   logic [RATIO-1:0]        out_keep;
   logic                    out_last;

   // Upsizer side: consumes narrow beats, produces packed words.
   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_keep, out_last
   );

   // Environment side: produces narrow beats, consumes packed words.
   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_keep, out_last
   );

endinterface

// File: rtl/stream_upsizer.sv
// Packs RATIO narrow beats (little-endian) into one wide word with a lane
// keep mask; in_last closes a word early and is carried to out_last.
module stream_upsizer
   import stream_pkg::*;
#(
   parameter int unsigned IN_W  = 8,
   parameter int unsigned RATIO = 4
) (
   input  logic              clk,
   input  logic              rst,
   stream_upsizer_if.slave   bus
);

   localparam int unsigned LW    = lane_w(RATIO);
   localparam int unsigned OUT_W = IN_W * RATIO;

   upsz_state_t   state;
   logic [LW-1:0] lane;
   logic          accept;
   logic          drain;
   logic          last_lane;

   // out_valid is a pure decode of the registered state, so there is no
   // combinational path from in_valid to out_valid.
   assign bus.out_valid = (state == HOLD);
   assign bus.in_ready  = !bus.out_valid || bus.out_ready;

   assign accept    = bus.in_valid && bus.in_ready;
   assign drain     = bus.out_valid && bus.out_ready;
   assign last_lane = (lane == LW'(RATIO - 1));

   // Accumulate beats directly into the output word register; the word is
   // cleared on drain so unused lanes of a short word read as zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= FILL;
         lane         <= '0;
         bus.out_data <= '0;
         bus.out_keep <= '0;
         bus.out_last <= 1'b0;
      end else begin
         case (state)
            FILL: begin
               if (accept) begin
                  bus.out_data[lane*IN_W +: IN_W] <= bus.in_data;
                  bus.out_keep[lane]              <= 1'b1;
                  if (last_lane || bus.in_last) begin
                     state        <= HOLD;
                     bus.out_last <= bus.in_last;
                     lane         <= '0;
                  end else begin
                     lane <= lane + LW'(1);
                  end
               end
            end
            HOLD: begin
               if (drain) begin
                  if (accept) begin
                     // Drain and refill on the same edge: new beat starts lane 0.
                     bus.out_data <= OUT_W'(bus.in_data);
                     bus.out_keep <= RATIO'(1);
                     bus.out_last <= bus.in_last;
                     if (bus.in_last) begin
                        state <= HOLD;
                        lane  <= '0;
                     end else begin
                        state <= FILL;
                        lane  <= LW'(1);
                     end
                  end else begin
                     bus.out_data <= '0;
                     bus.out_keep <= '0;
                     bus.out_last <= 1'b0;
                     state        <= FILL;
                     lane         <= '0;
                  end
               end
            end
            default: begin
               state <= FILL;
               lane  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stream_upsizer.sv
// Self-checking bench for stream_upsizer (IN_W=8, RATIO=4): directed
// scenarios plus randomized traffic against a beat-grouping scoreboard.
module tb_stream_upsizer;

   localparam int unsigned IN_W  = 8;
   localparam int unsigned RATIO = 4;

   logic clk = 1'b0;
   logic rst;

   stream_upsizer_if #(.IN_W(IN_W), .RATIO(RATIO)) bus ();

   stream_upsizer #(.IN_W(IN_W), .RATIO(RATIO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_words  = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: group accepted beats into words of up to RATIO beats,
   // closing early on in_last; each finished word is queued for comparison.
   logic [31:0] exp_data_q[$];
   logic [3:0]  exp_keep_q[$];
   logic        exp_last_q[$];
   logic [31:0] cur_data = '0;
   logic [3:0]  cur_keep = '0;
   int          cur_n    = 0;

   always @(negedge clk) begin
      if (rst) begin
         cur_data = '0;
         cur_keep = '0;
         cur_n    = 0;
         exp_data_q.delete();
         exp_keep_q.delete();
         exp_last_q.delete();
      end else begin
         check_eq("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
         if (bus.out_valid) begin
            if (exp_data_q.size() == 0) begin
               check_eq("unexpected_word", 1, 0);
            end else begin
               check_eq("sb_data", bus.out_data, exp_data_q[0]);
               check_eq("sb_keep", bus.out_keep, exp_keep_q[0]);
               check_eq("sb_last", bus.out_last, exp_last_q[0]);
               if (bus.out_ready) begin
                  void'(exp_data_q.pop_front());
                  void'(exp_keep_q.pop_front());
                  void'(exp_last_q.pop_front());
                  n_words++;
               end
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            cur_data = cur_data | (32'(bus.in_data) << (8 * cur_n));
            cur_keep[cur_n] = 1'b1;
            cur_n++;
            if (cur_n == RATIO || bus.in_last) begin
               exp_data_q.push_back(cur_data);
               exp_keep_q.push_back(cur_keep);
               exp_last_q.push_back(bus.in_last);
               cur_data = '0;
               cur_keep = '0;
               cur_n    = 0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [7:0] d, input logic l);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = l;
      tick();
      bus.in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      int sent;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      tick();
      check_eq("rst_out_valid", bus.out_valid, 0);
      check_eq("rst_out_data", bus.out_data, 0);
      check_eq("rst_out_keep", bus.out_keep, 0);
      check_eq("rst_out_last", bus.out_last, 0);
      check_eq("rst_in_ready", bus.in_ready, 1);
      rst = 1'b0;
      tick();
      check_eq("post_rst_in_ready", bus.in_ready, 1);

      // Full word, back-to-back, visible the cycle after the closing beat.
      bus.in_valid = 1'b1;
      bus.in_last  = 1'b0;
      bus.in_data  = 8'h11; tick();
      bus.in_data  = 8'h22; tick();
      bus.in_data  = 8'h33; tick();
      bus.in_data  = 8'h44; tick();
      bus.in_valid = 1'b0;
      check_eq("full_valid", bus.out_valid, 1);
      check_eq("full_data", bus.out_data, 32'h44332211);
      check_eq("full_keep", bus.out_keep, 4'b1111);
      check_eq("full_last", bus.out_last, 0);
      tick();
      check_eq("full_drained", bus.out_valid, 0);

      // Short packet of two beats.
      beat(8'hAA, 1'b0);
      beat(8'hBB, 1'b1);
      check_eq("two_data", bus.out_data, 32'h0000BBAA);
      check_eq("two_keep", bus.out_keep, 4'b0011);
      check_eq("two_last", bus.out_last, 1);
      tick();

      // Single-beat packet.
      beat(8'h5A, 1'b1);
      check_eq("one_data", bus.out_data, 32'h0000005A);
      check_eq("one_keep", bus.out_keep, 4'b0001);
      check_eq("one_last", bus.out_last, 1);
      tick();

      // Backpressure: word held for 3 cycles while a blocked beat is offered.
      bus.out_ready = 1'b0;
      beat(8'h01, 1'b0);
      beat(8'h02, 1'b0);
      beat(8'h03, 1'b0);
      beat(8'h04, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h99;
      bus.in_last  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check_eq("bp_in_ready", bus.in_ready, 0);
         check_eq("bp_valid", bus.out_valid, 1);
         check_eq("bp_data", bus.out_data, 32'h04030201);
         check_eq("bp_keep", bus.out_keep, 4'b1111);
         tick();
      end
      bus.out_ready = 1'b1;
      bus.in_data   = 8'h77;
      bus.in_last   = 1'b0;
      tick();
      bus.in_valid = 1'b0;
      check_eq("refill_valid", bus.out_valid, 0);
      check_eq("refill_data", bus.out_data, 32'h00000077);
      check_eq("refill_keep", bus.out_keep, 4'b0001);
      beat(8'h88, 1'b1);
      check_eq("refill2_data", bus.out_data, 32'h00008877);
      check_eq("refill2_keep", bus.out_keep, 4'b0011);
      check_eq("refill2_last", bus.out_last, 1);
      tick();

      // Reset mid-packet discards the partial word.
      beat(8'h01, 1'b0);
      beat(8'h02, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("midrst_keep", bus.out_keep, 0);
      beat(8'h03, 1'b0);
      beat(8'h04, 1'b0);
      beat(8'h05, 1'b0);
      beat(8'h06, 1'b0);
      check_eq("midrst_data", bus.out_data, 32'h06050403);
      check_eq("midrst_keep_full", bus.out_keep, 4'b1111);
      check_eq("midrst_last", bus.out_last, 0);
      tick();

      // Twelve beats with random gaps must yield exactly three words.
      w0   = n_words;
      sent = 0;
      while (sent < 12) begin
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.in_data  = 8'($urandom);
         bus.in_last  = 1'b0;
         if (bus.in_valid) sent++;
         tick();
      end
      bus.in_valid = 1'b0;
      tick();
      tick();
      check_eq("gap_words", n_words - w0, 3);

      // Random traffic with backpressure, early lasts and occasional reset.
      for (int i = 0; i < 600; i++) begin
         rst           = ($urandom_range(0, 149) == 0);
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.in_data   = 8'($urandom);
         bus.in_last   = ($urandom_range(0, 4) == 0);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      rst           = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      tick();
      tick();
      check_eq("sb_empty", exp_data_q.size(), 0);
      check_eq("final_valid", bus.out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/stream_upsizer.md
STREAM_UPSIZER -- requirements
Module: stream_upsizer

Interface
REQ-001 SHALL have parameter IN_W, default 8, meaning input beat width in bits.
REQ-002 SHALL have parameter RATIO, default 4, meaning input beats per output word; legal range 2..16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream beat valid.
REQ-006 SHALL have port in_ready, output, 1 bit: upstream beat accepted when in_valid && in_ready.
REQ-007 SHALL have port in_data, input, IN_W bits: beat payload.
REQ-008 SHALL have port in_last, input, 1 bit: beat closes the current packet.
REQ-009 SHALL have port out_valid, output, 1 bit: packed word valid.
REQ-010 SHALL have port out_ready, input, 1 bit: word consumed when out_valid && out_ready.
REQ-011 SHALL have port out_data, output, IN_W*RATIO bits: packed word.
REQ-012 SHALL have port out_keep, output, RATIO bits: per-lane valid mask.
REQ-013 SHALL have port out_last, output, 1 bit: word ends a packet.

Function
REQ-014 SHALL pack beats little-endian: the k-th accepted beat of a word goes to out_data[k*IN_W +: IN_W] and sets out_keep[k].
REQ-015 SHALL track the next free lane with a lane counter of $clog2(RATIO) bits, reset to 0.
REQ-016 SHALL use two states: FILL (out_valid=0) and HOLD (out_valid=1).
REQ-017 SHALL transition FILL->HOLD on the acceptance of the beat in lane RATIO-1, or of any beat with in_last=1.
REQ-018 SHALL transition HOLD->FILL on out_valid && out_ready with no simultaneous beat acceptance.
REQ-019 SHALL drive in_ready = !out_valid || out_ready, combinationally, with no other dependency.
REQ-020 SHALL, in HOLD, on a simultaneous drain and beat accept, load the beat into lane 0 and set out_keep=1 (only bit 0 set) in the same edge. Next state is HOLD if that beat closes the word (in_last), else FILL with lane counter 1.
REQ-021 SHALL assert out_valid the cycle after the closing beat is accepted; latency is 1 cycle from the closing beat.
REQ-022 SHALL zero all unused lanes of a partial word, and clear the corresponding out_keep bits.
REQ-023 SHALL set out_last=1 iff the word was closed by in_last; a full word whose final beat has in_last=1 has out_last=1 and out_keep all ones.
REQ-024 SHALL hold out_data, out_keep and out_last stable while out_valid && !out_ready.
REQ-025 SHALL ignore in_data and in_last when the beat is not accepted.
REQ-026 SHALL sustain one beat per cycle with out_ready held at 1 (no bubble between words).

Reset
REQ-027 SHALL, on rst=1 at a rising clk, set out_valid=0, out_data=0, out_keep=0, out_last=0, lane counter=0 and state FILL.
REQ-028 SHALL discard any partially filled word on reset mid-packet; the first beat after reset goes to lane 0.
REQ-029 SHALL drive in_ready=1 during and immediately after reset.

Structure
REQ-030 SHALL place the state enum (FILL, HOLD) and the lane-index width function in the shared package stream_pkg.
REQ-031 SHALL be a single module with no sub-module instances. Accumulator and output register SHALL be the same storage.
REQ-032 SHALL contain no latches and no combinational path from in_valid to out_valid.

Verification (IN_W=8, RATIO=4)
REQ-033 SHALL cover: beats 11,22,33,44 back-to-back with out_ready=1 -> cycle 5 out_data=0x44332211, out_keep=1111, out_last=0.
REQ-034 SHALL cover: beats AA,BB with in_last on BB -> out_data=0x0000BBAA, out_keep=0011, out_last=1.
REQ-035 SHALL cover: single beat 5A with in_last -> out_data=0x0000005A, out_keep=0001, out_last=1.
REQ-036 SHALL cover: full word held with out_ready=0 for 3 cycles -> in_ready=0, output stable. Then out_ready=1 with beat 77 -> word drained and 77 in lane 0 on the same edge.
REQ-037 SHALL cover: beats 01,02 then rst=1 for one cycle, then 03,04,05,06 -> single word 0x06050403; 01/02 never output.
REQ-038 SHALL cover: 12 consecutive beats, out_ready=1, random in_valid gaps -> 3 words in order, no beat lost or duplicated (scoreboard).
